serial_parity_rx: RTL and testbench
===================================

SERIAL_PARITY_RX -- requirements
Module: serial_parity_rx

Interface
REQ-001 Parameter DATA_W, default 8, number of data bits per frame (legal range 1..32).
REQ-002 Parameter ODD_PARITY, default 0; 0 selects even parity and 1 selects odd parity.
REQ-003 CLK  input  1  the single clock; all state updates on the rising edge.
REQ-004 RST_N  input  1  reset, asynchronous and active-low.
REQ-005 START  input  1  frame-start strobe, sampled only in IDLE.
REQ-006 DIN  input  1  serial data bit, LSB first, followed by one parity bit.
REQ-007 DIN_VALID  input  1  DIN qualifier; when low, the current cycle is a stall.
REQ-008 DOUT  output  DATA_W  received data word.
REQ-009 DOUT_VALID  output  1  one-cycle pulse marking a completed frame.
REQ-010 PAR_ERR  output  1  parity-error flag for the most recent frame.
REQ-011 BUSY  output  1  high whenever the state is not IDLE.

Function
REQ-012 The state machine SHALL have three states: IDLE, DATA and PARITY.
REQ-013 IDLE with START=1 SHALL move to DATA, clear the bit counter, and load the parity accumulator with ODD_PARITY; DIN is ignored in that cycle.
REQ-014 START SHALL be ignored in DATA and PARITY.
REQ-015 In DATA, each cycle with DIN_VALID=1 SHALL store DIN at bit position "count", XOR DIN into the accumulator, and increment count.
REQ-016 The accepted bit with count=DATA_W-1 SHALL move the state to PARITY.
REQ-017 In PARITY, DIN_VALID=1 SHALL register PAR_ERR = accumulator XOR DIN, register DOUT, and return the state to IDLE.
REQ-018 DOUT_VALID SHALL be high for exactly the one cycle after the parity bit is sampled, with DOUT and PAR_ERR valid in that same cycle.
REQ-019 DIN_VALID=0 in DATA or PARITY SHALL hold all state, with no timeout.
REQ-020 DOUT and PAR_ERR SHALL hold their values until the next DOUT_VALID.
REQ-021 Partial-frame bits SHALL NOT appear on DOUT.
REQ-022 START may arrive in the cycle in which DOUT_VALID is high, because the state is already IDLE; the next frame SHALL start without a dead cycle.
REQ-023 BUSY SHALL be 0 in IDLE and 1 in DATA and PARITY.

Reset
REQ-024 RST_N=0 SHALL, asynchronously, force the state to IDLE and clear count, the accumulator, the shift register, DOUT, DOUT_VALID, PAR_ERR and BUSY to 0, including when a frame is in progress.
REQ-025 A frame aborted by reset SHALL produce no DOUT_VALID.
REQ-026 After RST_N is released, the block SHALL wait for START.

Configuration
REQ-027 Macro SERIAL_PARITY_ERR_CNT_EN defined: the block SHALL add output ERR_CNT (input/output list: ERR_CNT  output  8  error count).
REQ-028 ERR_CNT SHALL increment on each DOUT_VALID with PAR_ERR=1, saturate at 255, and reset to 0.
REQ-029 Macro undefined: the ERR_CNT port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-030 The state encodings (IDLE=2'd0, DATA=2'd1, PARITY=2'd2) and the ERR_CNT width constant SHALL live in the shared package parity_pkg.
REQ-031 The accumulator XOR SHALL be implemented by one sub-module instance, xor_nand (two inputs, one output, four-NAND structure).

Verification
REQ-032 DATA_W=8, even parity: START, then bits 1,0,1,0,0,1,0,1, then parity bit 0 -> DOUT=0xA5, PAR_ERR=0, DOUT_VALID pulse one cycle after the parity bit.
REQ-033 Same frame with parity bit 1 -> DOUT=0xA5, PAR_ERR=1.
REQ-034 Frame 0x3C with DIN_VALID low for 3 cycles after bit 2 and 1 cycle before the parity bit -> DOUT=0x3C, PAR_ERR=0, BUSY high throughout.
REQ-035 RST_N pulsed low after bit 4 of a frame -> all outputs 0 at once, no DOUT_VALID; the next full frame 0xFF with parity bit 0 -> PAR_ERR=0.
REQ-036 ODD_PARITY=1: frame 0x00 with parity bit 1 -> PAR_ERR=0; frame 0x00 with parity bit 0 -> PAR_ERR=1; START in the DOUT_VALID cycle is accepted.
REQ-037 With SERIAL_PARITY_ERR_CNT_EN defined: 260 consecutive bad-parity frames -> ERR_CNT=255 and held.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared types and constants for the serial parity receiver.
// State encodings and the error-counter width used by serial_parity_rx.
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_e;

    localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/xor_nand.sv
// Two-input XOR built from four NAND gates.
// Used as the parity accumulator update in serial_parity_rx.
module xor_nand (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);

    logic n1, n2, n3;

    assign n1  = ~(a_i & b_i);
    assign n2  = ~(a_i & n1);
    assign n3  = ~(b_i & n1);
    assign y_o = ~(n2 & n3);

endmodule

// File: rtl/serial_parity_rx.sv
// Serial LSB-first receiver with trailing parity bit and stall support.
// Define SERIAL_PARITY_ERR_CNT_EN to add the saturating ERR_CNT output.
module serial_parity_rx
    import parity_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic              DIN,
    input  logic              DIN_VALID,
    output logic [DATA_W-1:0] DOUT,
    output logic              DOUT_VALID,
    output logic              PAR_ERR,
    output logic              BUSY
`ifdef SERIAL_PARITY_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] ERR_CNT
`endif
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    state_e            state_q;
    logic [CNT_W-1:0]  count_q;
    logic              acc_q;
    logic              acc_x;
    logic [DATA_W-1:0] shreg_q;
    logic [DATA_W-1:0] dout_q;
    logic              dout_valid_q;
    logic              par_err_q;
    logic              busy_q;

    xor_nand u_acc_xor (
        .a_i (acc_q),
        .b_i (DIN),
        .y_o (acc_x)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            count_q      <= '0;
            acc_q        <= 1'b0;
            shreg_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            dout_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (START) begin
                        state_q <= DATA;
                        count_q <= '0;
                        acc_q   <= ODD_PARITY;
                        busy_q  <= 1'b1;
                    end
                end
                DATA: begin
                    if (DIN_VALID) begin
                        shreg_q[count_q] <= DIN;
                        acc_q            <= acc_x;
                        count_q          <= count_q + 1'b1;
                        if (count_q == LAST) begin
                            state_q <= PARITY;
                        end
                    end
                end
                PARITY: begin
                    // Shift register is internal; DOUT only changes here.
                    if (DIN_VALID) begin
                        par_err_q    <= acc_x;
                        dout_q       <= shreg_q;
                        dout_valid_q <= 1'b1;
                        state_q      <= IDLE;
                        busy_q       <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign DOUT       = dout_q;
    assign DOUT_VALID = dout_valid_q;
    assign PAR_ERR    = par_err_q;
    assign BUSY       = busy_q;

`ifdef SERIAL_PARITY_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            err_cnt_q <= '0;
        end else if (dout_valid_q && par_err_q && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign ERR_CNT = err_cnt_q;
`endif

endmodule

// File: tb/tb_serial_parity_rx.sv
// Bench for serial_parity_rx: even and odd instances share one stimulus.
// Frame-level model plus literal checks; ERR_CNT checked when enabled.
module tb_serial_parity_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic [7:0] dout_e, dout_o;
    logic       dv_e, dv_o, perr_e, perr_o, busy_e, busy_o;
`ifdef SERIAL_PARITY_ERR_CNT_EN
    logic [7:0] ec_e, ec_o;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    serial_parity_rx #(.DATA_W(8), .ODD_PARITY(1'b0)) u_even (
        .CLK(clk), .RST_N(rst_n), .START(start), .DIN(din),
        .DIN_VALID(din_valid), .DOUT(dout_e), .DOUT_VALID(dv_e),
        .PAR_ERR(perr_e), .BUSY(busy_e)
`ifdef SERIAL_PARITY_ERR_CNT_EN
        , .ERR_CNT(ec_e)
`endif
    );

    serial_parity_rx #(.DATA_W(8), .ODD_PARITY(1'b1)) u_odd (
        .CLK(clk), .RST_N(rst_n), .START(start), .DIN(din),
        .DIN_VALID(din_valid), .DOUT(dout_o), .DOUT_VALID(dv_o),
        .PAR_ERR(perr_o), .BUSY(busy_o)
`ifdef SERIAL_PARITY_ERR_CNT_EN
        , .ERR_CNT(ec_o)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Frame-level model: collect accepted bits, then judge the whole word.
    bit       q[$];
    bit       m_busy = 1'b0;
    bit       m_valid = 1'b0;
    bit [7:0] m_dout = '0;
    bit       m_perr_e = 1'b0;
    bit       m_perr_o = 1'b0;
    bit [7:0] m_ec_e = '0;
    bit [7:0] m_ec_o = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_busy   <= 1'b0;
            m_valid  <= 1'b0;
            m_dout   <= '0;
            m_perr_e <= 1'b0;
            m_perr_o <= 1'b0;
            m_ec_e   <= '0;
            m_ec_o   <= '0;
        end else begin
            m_valid <= 1'b0;
            if (m_valid && m_perr_e && m_ec_e != 8'd255) m_ec_e <= m_ec_e + 8'd1;
            if (m_valid && m_perr_o && m_ec_o != 8'd255) m_ec_o <= m_ec_o + 8'd1;
            if (!m_busy) begin
                if (start) begin
                    q.delete();
                    m_busy <= 1'b1;
                end
            end else if (din_valid) begin
                if (q.size() < 8) begin
                    q.push_back(din);
                end else begin
                    automatic int ones = 0;
                    automatic bit [7:0] w = '0;
                    for (int i = 0; i < 8; i++) begin
                        w = w | (8'(q[i]) << i);
                        ones += int'(q[i]);
                    end
                    m_dout   <= w;
                    m_perr_e <= ((ones + int'(din)) % 2) != 0;
                    m_perr_o <= ((ones + int'(din) + 1) % 2) != 0;
                    m_valid  <= 1'b1;
                    m_busy   <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("even_dv", 32'(dv_e), 32'(m_valid));
        chk("odd_dv", 32'(dv_o), 32'(m_valid));
        chk("even_busy", 32'(busy_e), 32'(m_busy));
        chk("odd_busy", 32'(busy_o), 32'(m_busy));
        chk("even_dout", 32'(dout_e), 32'(m_dout));
        chk("odd_dout", 32'(dout_o), 32'(m_dout));
        chk("even_perr", 32'(perr_e), 32'(m_perr_e));
        chk("odd_perr", 32'(perr_o), 32'(m_perr_o));
`ifdef SERIAL_PARITY_ERR_CNT_EN
        chk("even_errcnt", 32'(ec_e), 32'(m_ec_e));
        chk("odd_errcnt", 32'(ec_o), 32'(m_ec_o));
`endif
    end

    task automatic drive(input logic st, input logic b, input logic v);
        @(negedge clk);
        start     = st;
        din       = b;
        din_valid = v;
    endtask

    // DIN is held valid in the start cycle to show it is ignored.
    task automatic start_cycle();
        drive(1'b1, 1'b1, 1'b1);
    endtask

    task automatic frame_body(input logic [7:0] d, input logic p,
                              input int stall_after, input int stall_n,
                              input int pre_par);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, d[i], 1'b1);
            if (i == stall_after) begin
                for (int s = 0; s < stall_n; s++) begin
                    drive(1'b1, ~d[i], 1'b0);
                    chk("stall_busy", 32'(busy_e), 32'd1);
                end
            end
        end
        for (int s = 0; s < pre_par; s++) begin
            drive(1'b1, ~p, 1'b0);
            chk("prepar_busy", 32'(busy_e), 32'd1);
        end
        drive(1'b0, p, 1'b1);
    endtask

    task automatic end_frame(input logic chain, input logic [7:0] d,
                             input logic pe, input logic po);
        drive(chain, 1'b0, 1'b0);
        chk("lit_dv", 32'(dv_e), 32'd1);
        chk("lit_dout", 32'(dout_e), 32'(d));
        chk("lit_perr_even", 32'(perr_e), 32'(pe));
        chk("lit_perr_odd", 32'(perr_o), 32'(po));
        chk("lit_busy_idle", 32'(busy_e), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_dout", 32'(dout_e), 32'd0);
        chk("rst_busy", 32'(busy_e), 32'd0);
        rst_n = 1'b1;
        repeat (2) drive(1'b0, 1'b1, 1'b1);

        start_cycle();
        frame_body(8'hA5, 1'b0, -1, 0, 0);
        end_frame(1'b0, 8'hA5, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        chk("dv_one_cycle", 32'(dv_e), 32'd0);
        chk("dout_hold", 32'(dout_e), 32'hA5);

        start_cycle();
        frame_body(8'hA5, 1'b1, -1, 0, 0);
        end_frame(1'b0, 8'hA5, 1'b1, 1'b0);

        start_cycle();
        frame_body(8'h3C, 1'b0, 2, 3, 1);
        end_frame(1'b0, 8'h3C, 1'b0, 1'b1);

        start_cycle();
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        chk("pre_rst_busy", 32'(busy_e), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_dout", 32'(dout_e), 32'd0);
        chk("arst_dv", 32'(dv_e), 32'd0);
        chk("arst_perr", 32'(perr_e), 32'd0);
        chk("arst_busy_e", 32'(busy_e), 32'd0);
        chk("arst_busy_o", 32'(busy_o), 32'd0);
        drive(1'b0, 1'b1, 1'b1);
        rst_n = 1'b1;
        repeat (3) drive(1'b0, 1'b1, 1'b1);
        chk("post_rst_idle", 32'(busy_e), 32'd0);

        start_cycle();
        frame_body(8'hFF, 1'b0, -1, 0, 0);
        end_frame(1'b0, 8'hFF, 1'b0, 1'b1);

        start_cycle();
        frame_body(8'h00, 1'b1, -1, 0, 0);
        end_frame(1'b1, 8'h00, 1'b1, 1'b0);
        frame_body(8'h00, 1'b0, -1, 0, 0);
        end_frame(1'b0, 8'h00, 1'b0, 1'b1);

`ifdef SERIAL_PARITY_ERR_CNT_EN
        for (int f = 0; f < 260; f++) begin
            start_cycle();
            frame_body(8'h00, 1'b1, -1, 0, 0);
            end_frame(1'b0, 8'h00, 1'b1, 1'b0);
        end
        repeat (2) drive(1'b0, 1'b0, 1'b0);
        chk("errcnt_sat", 32'(ec_e), 32'd255);
        repeat (5) drive(1'b0, 1'b0, 1'b0);
        chk("errcnt_hold", 32'(ec_e), 32'd255);
`endif

        repeat (3) drive(1'b0, 1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
